// File: rtl/decoder_4b3b.sv
// ---------------------------------------------------------------------------
// decoder_4b3b
// Receive-side 4b/3b decoder. Decodes 4-bit sub-symbols against the
// running-disparity code tables and flags code/disparity violations. It also
// runs a two-state lock FSM and keeps a saturating error counter.
//
// Ports
//   clk_i              single clock
//   rst_ni             synchronous active-low reset
//   data_i [3:0]       encoded sub-symbol
//   valid_i            data_i qualifier
//   err_count_clr_i    clears err_count_o (same edge)
//   data_o [2:0]       decoded data (1-cycle latency)
//   valid_o            output qualifier
//   run_disparity_n_o  current running disparity, 1 = negative
//   code_err_o         symbol is in neither table
//   disp_err_o         symbol is only valid under the opposite disparity
//   locked_o           lock FSM is in LOCKED
//   err_count_o        saturating count of erroneous valid symbols
//
// Lock FSM
//   state       | meaning
//   ST_UNLOCKED | counting consecutive good symbols toward LOCK_GOOD_CNT
//   ST_LOCKED   | counting consecutive bad symbols toward UNLOCK_ERR_CNT
// ---------------------------------------------------------------------------
module decoder_4b3b #(
    parameter logic RD_N_INIT      = 1'b0,
    parameter int   LOCK_GOOD_CNT  = 8,
    parameter int   UNLOCK_ERR_CNT = 4,
    parameter int   ERR_CNT_W      = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [3:0]           data_i,
    input  logic                 valid_i,
    input  logic                 err_count_clr_i,
    output logic [2:0]           data_o,
    output logic                 valid_o,
    output logic                 run_disparity_n_o,
    output logic                 code_err_o,
    output logic                 disp_err_o,
    output logic                 locked_o,
    output logic [ERR_CNT_W-1:0] err_count_o
);

    localparam int GOOD_W = $clog2(LOCK_GOOD_CNT + 1);
    localparam int BAD_W  = $clog2(UNLOCK_ERR_CNT + 1);

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [GOOD_W-1:0]      r_good_run;
    logic [GOOD_W-1:0]      w_good_nxt;
    logic [BAD_W-1:0]       r_err_run;
    logic [BAD_W-1:0]       w_err_nxt;
    logic [2:0]             r_data;
    logic                   r_valid;
    logic                   r_rd_n;
    logic                   r_code_err;
    logic                   r_disp_err;
    logic [ERR_CNT_W-1:0]   r_err_cnt;

    logic                   w_neg_hit;
    logic [2:0]             w_neg_data;
    logic                   w_neg_nrd;
    logic                   w_pos_hit;
    logic [2:0]             w_pos_data;
    logic                   w_pos_nrd;
    logic                   w_cur_hit;
    logic                   w_opp_hit;
    logic                   w_code_err;
    logic                   w_disp_err;
    logic                   w_sym_err;
    logic [2:0]             w_dec_data;
    logic                   w_dec_rd_n;

    // Negative-disparity table; only 1110 (data 7) moves RD to positive.
    always_comb begin
        w_neg_hit  = 1'b1;
        w_neg_data = 3'd0;
        w_neg_nrd  = 1'b1;
        case (data_i)
            4'b0100: w_neg_data = 3'd0;
            4'b1001: w_neg_data = 3'd1;
            4'b0101: w_neg_data = 3'd2;
            4'b1100: w_neg_data = 3'd3;
            4'b0010: w_neg_data = 3'd4;
            4'b1010: w_neg_data = 3'd5;
            4'b0110: w_neg_data = 3'd6;
            4'b1110: begin
                w_neg_data = 3'd7;
                w_neg_nrd  = 1'b0;
            end
            default: w_neg_hit = 1'b0;
        endcase
    end

    // Positive-disparity table; only 0001 (data 7) moves RD to negative.
    always_comb begin
        w_pos_hit  = 1'b1;
        w_pos_data = 3'd0;
        w_pos_nrd  = 1'b0;
        case (data_i)
            4'b1011: w_pos_data = 3'd0;
            4'b1001: w_pos_data = 3'd1;
            4'b0101: w_pos_data = 3'd2;
            4'b0011: w_pos_data = 3'd3;
            4'b1101: w_pos_data = 3'd4;
            4'b1010: w_pos_data = 3'd5;
            4'b0110: w_pos_data = 3'd6;
            4'b0001: begin
                w_pos_data = 3'd7;
                w_pos_nrd  = 1'b1;
            end
            default: w_pos_hit = 1'b0;
        endcase
    end

    // A disparity error still decodes through the opposite table so the
    // receiver resynchronises its RD to the transmitter.
    always_comb begin
        w_cur_hit  = r_rd_n ? w_neg_hit : w_pos_hit;
        w_opp_hit  = r_rd_n ? w_pos_hit : w_neg_hit;
        w_code_err = !w_neg_hit && !w_pos_hit;
        w_disp_err = !w_cur_hit && w_opp_hit;
        w_sym_err  = w_code_err || w_disp_err;
        w_dec_data = 3'd0;
        w_dec_rd_n = r_rd_n;
        if (w_neg_hit && (r_rd_n || !w_pos_hit)) begin
            w_dec_data = w_neg_data;
            w_dec_rd_n = w_neg_nrd;
        end else if (w_pos_hit) begin
            w_dec_data = w_pos_data;
            w_dec_rd_n = w_pos_nrd;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good_run;
        w_err_nxt   = r_err_run;
        if (valid_i) begin
            case (r_state)
                ST_UNLOCKED: begin
                    if (w_sym_err) begin
                        w_good_nxt = '0;
                    end else if (r_good_run == GOOD_W'(LOCK_GOOD_CNT - 1)) begin
                        w_state_nxt = ST_LOCKED;
                        w_good_nxt  = '0;
                        w_err_nxt   = '0;
                    end else begin
                        w_good_nxt = r_good_run + 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (!w_sym_err) begin
                        w_err_nxt = '0;
                    end else if (r_err_run == BAD_W'(UNLOCK_ERR_CNT - 1)) begin
                        w_state_nxt = ST_UNLOCKED;
                        w_good_nxt  = '0;
                        w_err_nxt   = '0;
                    end else begin
                        w_err_nxt = r_err_run + 1'b1;
                    end
                end
                default: w_state_nxt = ST_UNLOCKED;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state    <= ST_UNLOCKED;
            r_good_run <= '0;
            r_err_run  <= '0;
            r_data     <= 3'd0;
            r_valid    <= 1'b0;
            r_rd_n     <= RD_N_INIT;
            r_code_err <= 1'b0;
            r_disp_err <= 1'b0;
            r_err_cnt  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_good_run <= w_good_nxt;
            r_err_run  <= w_err_nxt;
            r_valid    <= valid_i;
            r_code_err <= valid_i && w_code_err;
            r_disp_err <= valid_i && w_disp_err;
            if (valid_i) begin
                r_data <= w_dec_data;
                r_rd_n <= w_dec_rd_n;
            end
            if (err_count_clr_i) begin
                r_err_cnt <= (valid_i && w_sym_err) ? ERR_CNT_W'(1) : '0;
            end else if (valid_i && w_sym_err && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end

    assign data_o            = r_data;
    assign valid_o           = r_valid;
    assign run_disparity_n_o = r_rd_n;
    assign code_err_o        = r_code_err;
    assign disp_err_o        = r_disp_err;
    assign locked_o          = (r_state == ST_LOCKED);
    assign err_count_o       = r_err_cnt;

endmodule

// File: tb/tb_decoder_4b3b.sv
module tb_decoder_4b3b;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [3:0]  data_i;
    logic        valid_i;
    logic        err_count_clr_i;
    logic [2:0]  data_o;
    logic        valid_o;
    logic        run_disparity_n_o;
    logic        code_err_o;
    logic        disp_err_o;
    logic        locked_o;
    logic [15:0] err_count_o;

    int checks   = 0;
    int failures = 0;

    decoder_4b3b dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .data_i            (data_i),
        .valid_i           (valid_i),
        .err_count_clr_i   (err_count_clr_i),
        .data_o            (data_o),
        .valid_o           (valid_o),
        .run_disparity_n_o (run_disparity_n_o),
        .code_err_o        (code_err_o),
        .disp_err_o        (disp_err_o),
        .locked_o          (locked_o),
        .err_count_o       (err_count_o)
    );

    always #5 clk_i = ~clk_i;

    // Code tables indexed by data value.
    logic [3:0] neg_tab [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b1100,
                                4'b0010, 4'b1010, 4'b0110, 4'b1110};
    logic [3:0] pos_tab [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b0011,
                                4'b1101, 4'b1010, 4'b0110, 4'b0001};

    // Reference model state
    int   m_data, m_cnt, m_good, m_bad;
    bit   m_valid, m_rdn, m_cerr, m_derr, m_locked;

    function automatic int find(input bit rdn, input logic [3:0] code);
        for (int i = 0; i < 8; i++)
            if ((rdn ? neg_tab[i] : pos_tab[i]) == code) return i;
        return -1;
    endfunction

    task automatic model_step(input bit rst_n, input bit v, input logic [3:0] d, input bit clr);
        int  idx;
        bit  err;
        if (!rst_n) begin
            m_data = 0; m_valid = 0; m_rdn = 0; m_cerr = 0; m_derr = 0;
            m_locked = 0; m_good = 0; m_bad = 0; m_cnt = 0;
            return;
        end
        m_valid = v; m_cerr = 0; m_derr = 0; err = 0;
        if (v) begin
            idx = find(m_rdn, d);
            if (idx >= 0) begin
                m_data = idx;
                if (idx == 7) m_rdn = !m_rdn;
            end else begin
                idx = find(!m_rdn, d);
                if (idx >= 0) begin
                    m_derr = 1;
                    m_data = idx;
                    // opposite table's data 7 flips back to current RD; others stay opposite
                    if (idx != 7) m_rdn = !m_rdn;
                end else begin
                    m_cerr = 1;
                    m_data = 0;
                end
            end
            err = m_cerr | m_derr;
            if (!m_locked) begin
                if (err) m_good = 0;
                else begin
                    m_good++;
                    if (m_good == 8) begin m_locked = 1; m_good = 0; m_bad = 0; end
                end
            end else begin
                if (!err) m_bad = 0;
                else begin
                    m_bad++;
                    if (m_bad == 4) begin m_locked = 0; m_good = 0; m_bad = 0; end
                end
            end
        end
        if (clr) m_cnt = (v && err) ? 1 : 0;
        else if (v && err && m_cnt < 65535) m_cnt++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit rst_n, input bit v, input logic [3:0] d, input bit clr);
        @(negedge clk_i);
        rst_ni = rst_n; valid_i = v; data_i = d; err_count_clr_i = clr;
        @(posedge clk_i);
        #1;
        model_step(rst_n, v, d, clr);
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".data"},   32'(data_o),            32'(m_data));
        check({tag, ".valid"},  32'(valid_o),           32'(m_valid));
        check({tag, ".rdn"},    32'(run_disparity_n_o), 32'(m_rdn));
        check({tag, ".cerr"},   32'(code_err_o),        32'(m_cerr));
        check({tag, ".derr"},   32'(disp_err_o),        32'(m_derr));
        check({tag, ".locked"}, 32'(locked_o),          32'(m_locked));
        check({tag, ".cnt"},    32'(err_count_o),       32'(m_cnt));
    endtask

    typedef struct {
        bit         v;
        logic [3:0] d;
        bit         clr;
        logic [2:0] e_data;
        bit         e_valid;
        bit         e_rdn;
        bit         e_cerr;
        bit         e_derr;
        int         e_cnt;
    } vec_t;

    vec_t vecs [14];

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        bit rst_n, v, clr;
        logic [3:0] d;

        vecs[0]  = '{1, 4'b1011, 0, 3'd0, 1, 0, 0, 0, 0};
        vecs[1]  = '{1, 4'b1001, 0, 3'd1, 1, 0, 0, 0, 0};
        vecs[2]  = '{1, 4'b0001, 0, 3'd7, 1, 1, 0, 0, 0};
        vecs[3]  = '{1, 4'b0100, 0, 3'd0, 1, 1, 0, 0, 0};
        vecs[4]  = '{1, 4'b1011, 0, 3'd0, 1, 0, 0, 1, 1};
        vecs[5]  = '{1, 4'b1111, 0, 3'd0, 1, 0, 1, 0, 2};
        vecs[6]  = '{1, 4'b0011, 0, 3'd3, 1, 0, 0, 0, 2};
        vecs[7]  = '{0, 4'b0000, 0, 3'd3, 0, 0, 0, 0, 2};
        vecs[8]  = '{1, 4'b1110, 0, 3'd7, 1, 0, 0, 1, 3};
        vecs[9]  = '{1, 4'b0001, 0, 3'd7, 1, 1, 0, 0, 3};
        vecs[10] = '{1, 4'b1110, 0, 3'd7, 1, 0, 0, 0, 3};
        vecs[11] = '{1, 4'b0000, 0, 3'd0, 1, 0, 1, 0, 4};
        vecs[12] = '{0, 4'b0100, 1, 3'd0, 0, 0, 0, 0, 0};
        vecs[13] = '{1, 4'b1000, 1, 3'd0, 1, 0, 1, 0, 1};

        rst_ni = 1'b0; valid_i = 1'b0; data_i = 4'h0; err_count_clr_i = 1'b0;

        // Reset values
        step(0, 0, 4'h0, 0);
        step(0, 0, 4'h0, 0);
        check("rst.data",   32'(data_o), 0);
        check("rst.valid",  32'(valid_o), 0);
        check("rst.rdn",    32'(run_disparity_n_o), 0);
        check("rst.cerr",   32'(code_err_o), 0);
        check("rst.derr",   32'(disp_err_o), 0);
        check("rst.locked", 32'(locked_o), 0);
        check("rst.cnt",    32'(err_count_o), 0);

        // Directed decode table
        for (int i = 0; i < 14; i++) begin
            step(1, vecs[i].v, vecs[i].d, vecs[i].clr);
            check($sformatf("vec%0d.data", i),  32'(data_o),            32'(vecs[i].e_data));
            check($sformatf("vec%0d.valid", i), 32'(valid_o),           32'(vecs[i].e_valid));
            check($sformatf("vec%0d.rdn", i),   32'(run_disparity_n_o), 32'(vecs[i].e_rdn));
            check($sformatf("vec%0d.cerr", i),  32'(code_err_o),        32'(vecs[i].e_cerr));
            check($sformatf("vec%0d.derr", i),  32'(disp_err_o),        32'(vecs[i].e_derr));
            check($sformatf("vec%0d.cnt", i),   32'(err_count_o),       32'(vecs[i].e_cnt));
        end

        // Lock acquisition with gaps, then loss
        step(0, 0, 4'h0, 0);
        for (int i = 1; i <= 8; i++) begin
            step(1, 1, 4'b1001, 0);
            check($sformatf("lock.good%0d", i), 32'(locked_o), (i == 8) ? 1 : 0);
            if (i < 8) begin
                step(1, 0, 4'b0000, 0);
                check($sformatf("lock.gap%0d", i), 32'(locked_o), 0);
            end
        end
        for (int i = 1; i <= 3; i++) begin
            step(1, 1, 4'b1111, 0);
            check($sformatf("lock.err3_%0d", i), 32'(locked_o), 1);
        end
        step(1, 1, 4'b1001, 0);
        check("lock.good_mid", 32'(locked_o), 1);
        for (int i = 1; i <= 4; i++) begin
            step(1, 1, 4'b1111, 0);
            check($sformatf("lock.err4_%0d", i), 32'(locked_o), (i == 4) ? 0 : 1);
        end

        // Error counter saturation
        step(0, 0, 4'h0, 0);
        repeat (65535) step(1, 1, 4'b1111, 0);
        check("sat.full", 32'(err_count_o), 32'hFFFF);
        check("sat.rdn",  32'(run_disparity_n_o), 0);
        step(1, 1, 4'b1111, 0);
        check("sat.hold", 32'(err_count_o), 32'hFFFF);
        step(1, 1, 4'b1111, 1);
        check("sat.clr_err", 32'(err_count_o), 1);
        step(1, 1, 4'b1001, 1);
        check("sat.clr_good", 32'(err_count_o), 0);

        // Mid-stream reset discards the in-flight symbol
        step(0, 0, 4'h0, 0);
        step(1, 1, 4'b0001, 0);
        step(1, 1, 4'b0100, 0);
        check("mid.pre_rdn", 32'(run_disparity_n_o), 1);
        step(0, 1, 4'b0001, 0);
        check("mid.valid", 32'(valid_o), 0);
        check("mid.data",  32'(data_o), 0);
        check("mid.rdn",   32'(run_disparity_n_o), 0);
        check("mid.cnt",   32'(err_count_o), 0);
        step(1, 1, 4'b1001, 0);
        check("mid.after_data", 32'(data_o), 1);
        check("mid.after_rdn",  32'(run_disparity_n_o), 0);
        check("mid.after_derr", 32'(disp_err_o), 0);

        // Randomised run against the reference model
        step(0, 0, 4'h0, 0);
        for (int n = 0; n < 4000; n++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            v     = ($urandom_range(0, 9) < 7);
            clr   = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 9) < 8) begin
                k = $urandom_range(0, 7);
                d = m_rdn ? neg_tab[k] : pos_tab[k];
            end else begin
                d = 4'($urandom);
            end
            step(rst_n, v, d, clr);
            compare_all($sformatf("rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decoder_4b3b.md
Name: decoder_4b3b

Overview:
- Receive-side counterpart of the 3b/4b encoder in the PCIe physical-layer path.
- Accepts 4-bit sub-symbols from the deserializer/alignment stage and tracks running disparity against the encoder's code table.
- Outputs the decoded 3-bit data with per-symbol code-violation and disparity-error flags.
- Runs a lock state machine and a saturating error counter for link-status logic.

Parameters:
- RD_N_INIT, 1'b0: running-disparity state after reset (1 = negative, 0 = positive); matches the encoder reset state.
- LOCK_GOOD_CNT, 8: consecutive error-free valid symbols needed to enter LOCKED.
- UNLOCK_ERR_CNT, 4: consecutive erroneous valid symbols needed to drop to UNLOCKED.
- ERR_CNT_W, 16: width of the error counter.

Ports:
- clk_i  in  1  single clock.
- rst_ni  in  1  reset; synchronous, active-low.
- data_i  in  4  encoded sub-symbol.
- valid_i  in  1  data_i qualifier.
- err_count_clr_i  in  1  clears err_count_o.
- data_o  out  3  decoded data.
- valid_o  out  1  output qualifier.
- run_disparity_n_o  out  1  current running disparity (1 = negative).
- code_err_o  out  1  symbol is in neither table.
- disp_err_o  out  1  symbol is valid only under the opposite disparity.
- locked_o  out  1  lock FSM is in LOCKED.
- err_count_o  out  ERR_CNT_W  saturating count of erroneous symbols.

Behaviour:
- Reset (rst_ni low at a clk_i edge) sets:
  - data_o = 0, valid_o = 0, code_err_o = 0, disp_err_o = 0
  - run_disparity_n_o = RD_N_INIT
  - FSM = UNLOCKED, locked_o = 0
  - both run counters = 0, err_count_o = 0
- Reset mid-stream discards the in-flight symbol.
- Decode tables (code -> data / next RD):
  - RD negative: 0100->000/neg, 1001->001/neg, 0101->010/neg, 1100->011/neg, 0010->100/neg, 1010->101/neg, 0110->110/neg, 1110->111/pos.
  - RD positive: 1011->000/pos, 1001->001/pos, 0101->010/pos, 0011->011/pos, 1101->100/pos, 1010->101/pos, 0110->110/pos, 0001->111/neg.
- Latency: exactly 1 cycle. A symbol with valid_i = 1 at edge N appears on data_o, valid_o, the error flags and run_disparity_n_o after edge N.
- valid_i = 0 at an edge:
  - valid_o = 0 and both error flags = 0.
  - data_o, RD, FSM and counters hold.
- Hit in the table for the current RD:
  - Output that entry's data and take its next RD.
  - Both error flags = 0.
- Miss in the current-RD table but hit in the opposite table (e.g. 1011 while RD negative):
  - disp_err_o = 1.
  - Decode with the opposite table and take that entry's next RD (resync).
- Miss in both tables (0000, 0111, 1000, 1111):
  - code_err_o = 1, data_o = 000, RD unchanged.
  - Flags are mutually exclusive.
- Symbol error = code_err or disp_err on a valid symbol.
- Lock FSM, two states:
  - UNLOCKED: each good symbol increments good_run; any error clears good_run. When good_run would reach LOCK_GOOD_CNT, go to LOCKED and clear both runs.
  - LOCKED: each error increments err_run; any good symbol clears err_run. When err_run would reach UNLOCK_ERR_CNT, go to UNLOCKED and clear both runs.
  - locked_o is registered and updates in the same cycle as valid_o for the triggering symbol.
- err_count_o:
  - Increments by 1 per erroneous valid symbol and saturates at all-ones.
  - err_count_clr_i alone sets it to 0.
  - err_count_clr_i with a simultaneous error sets it to 1.
  - Clear is effective in the same edge.
- Invalid cycles between symbols do not break good/error runs.

Test Plan:
- Reset with RD_N_INIT = 0 -> all outputs 0, run_disparity_n_o = 0, locked_o = 0, err_count_o = 0.
- From RD positive, feed 1011,1001,0001,0100 with valid_i = 1 -> data_o 000,001,111,000 one cycle later; RD pos,pos,neg,neg; no error flags.
- From RD negative, feed 1011 -> disp_err_o = 1, data_o = 000, RD becomes positive; err_count_o = 1.
- Feed 1111 -> code_err_o = 1, data_o = 000, RD unchanged. Repeat until err_count_o = 0xFFFF, feed one more error -> stays 0xFFFF. Assert err_count_clr_i with an error -> 1.
- 8 good symbols with valid_i gaps between them -> locked_o rises with the 8th valid_o. Then 3 errors, 1 good, 4 errors -> locked_o falls with the 4th consecutive error only.
- Assert rst_ni low mid-stream with valid_i = 1 -> next cycle valid_o = 0 and all state is at reset values. The in-flight symbol never appears.
